// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for the sequential execute-stage ALU.
// Both directions use a valid/ready handshake.
interface alu_seq_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;

  modport master (
    output in_valid,
    input  in_ready,
    output Operation,
    output SrcA,
    output SrcB,
    input  out_valid,
    output out_ready,
    input  ALUResult,
    input  Zero
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  Operation,
    input  SrcA,
    input  SrcB,
    output out_valid,
    input  out_ready,
    output ALUResult,
    output Zero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops and an
// iterative 1-bit-per-cycle shifter, with valid/ready on both sides.
module alu_seq_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input logic          clk,
  input logic          reset,
  alu_seq_unit_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);
  localparam logic [DATA_WIDTH-2:0]  PAD0    = '0;

  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_zero;
  logic [DATA_WIDTH-1:0]   r_work;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic [1:0]              r_kind;

  logic [SHAMT_WIDTH-1:0]  w_shamt;
  logic                    w_is_shift;
  logic [DATA_WIDTH-1:0]   w_alu;
  logic [DATA_WIDTH-1:0]   w_shifted;

  assign w_shamt = bus.SrcB[SHAMT_WIDTH-1:0];

  assign w_is_shift = (bus.Operation == OP_SLL) ||
                      (bus.Operation == OP_SRL) ||
                      (bus.Operation == OP_SRA);

  // Shifts by zero fall through here and return SrcA unchanged.
  always_comb begin
    w_alu = '0;
    case (bus.Operation)
      OP_AND:  w_alu = bus.SrcA & bus.SrcB;
      OP_SUB:  w_alu = bus.SrcA - bus.SrcB;
      OP_ADD:  w_alu = bus.SrcA + bus.SrcB;
      OP_OR:   w_alu = bus.SrcA | bus.SrcB;
      OP_XOR:  w_alu = bus.SrcA ^ bus.SrcB;
      OP_SLL:  w_alu = bus.SrcA;
      OP_SRL:  w_alu = bus.SrcA;
      OP_SRA:  w_alu = bus.SrcA;
      OP_EQ:   w_alu = {PAD0, bus.SrcA == bus.SrcB};
      OP_SLT:  w_alu = {PAD0,
                        $signed(bus.SrcA) < $signed(bus.SrcB)};
      OP_SLTU: w_alu = {PAD0, bus.SrcA < bus.SrcB};
      default: w_alu = '0;
    endcase
  end

  // r_kind holds Operation[1:0]: 01 SLL, 10 SRL, 11 SRA.
  always_comb begin
    w_shifted = r_work;
    unique case (1'b1)
      (r_kind == 2'b01): w_shifted = {r_work[DATA_WIDTH-2:0], 1'b0};
      (r_kind == 2'b10): w_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
      (r_kind == 2'b11): w_shifted = {r_work[DATA_WIDTH-1],
                                      r_work[DATA_WIDTH-1:1]};
      default:           w_shifted = r_work;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_kind      <= 2'b00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            if (w_is_shift && (w_shamt != '0)) begin
              r_work  <= bus.SrcA;
              r_cnt   <= w_shamt;
              r_kind  <= bus.Operation[1:0];
              r_state <= S_SHIFT;
            end else begin
              r_result    <= w_alu;
              r_zero      <= (w_alu == '0);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_result    <= w_shifted;
            r_zero      <= (w_shifted == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ALUResult = r_result;
  assign bus.Zero      = r_zero;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit: a driver queues expected
// responses, a negedge monitor pops and compares them.
module tb_alu_seq_unit;
  logic clk;
  logic reset;

  alu_seq_unit_if #(.DATA_WIDTH(32)) bus ();

  alu_seq_unit #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nvec;
  int          nerr;
  int          cyc;
  int          acc_cyc;
  logic        prev_ov;
  logic [31:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on the first cycle out_valid is seen, then
  // check the result stays stable while it is held.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL spurious_out: got result %h expected none",
                   bus.ALUResult);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", bus.ALUResult, e.res);
          check("zero", 32'(bus.Zero), 32'(e.zero));
          check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          held <= e.res;
        end
      end else if (bus.out_valid && prev_ov) begin
        check("held_result", bus.ALUResult, held);
      end
      prev_ov <= bus.out_valid;
    end
  end

  task automatic wait_in_ready();
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input int lat, input int hold);
    exp_t e;
    int   t;
    @(negedge clk);
    wait_in_ready();
    e.res  = res;
    e.zero = (res == 32'h0);
    e.lat  = lat;
    sb.push_back(e);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    acc_cyc       = cyc;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.Operation = 4'b0010;
    bus.SrcA      = 32'hDEAD_BEEF;
    bus.SrcB      = 32'h1357_9BDF;
    @(negedge clk);
    t = 0;
    while (!bus.out_valid && t < 40) begin
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) begin
      nvec++;
      nerr++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    nvec          = 0;
    nerr          = 0;
    cyc           = 0;
    acc_cyc       = 0;
    held          = '0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Operation = 4'b0000;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.ALUResult, 32'h0);
    check("rst_zero", 32'(bus.Zero), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    issue(4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, 0);
    issue(4'b1001, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1, 0);
    issue(4'b1010, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1, 0);
    issue(4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1, 0);
    issue(4'b1000, 32'h0000_1234, 32'h0000_1235, 32'h0000_0000, 1, 0);
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1, 0);
    issue(4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1, 0);
    issue(4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 5, 0);
    issue(4'b0101, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1, 0);
    issue(4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32, 0);
    issue(4'b0101, 32'h0000_0003, 32'h0000_0001, 32'h0000_0006, 2, 0);
    issue(4'b0110, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5, 0);
    issue(4'b0111, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000, 5, 0);
    issue(4'b1011, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1, 0);
    issue(4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1, 4);
    issue(4'b0010, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1, 0);

    // Reset during the third shift cycle of SLL by 10 must abort it.
    @(negedge clk);
    wait_in_ready();
    bus.in_valid  = 1'b1;
    bus.Operation = 4'b0101;
    bus.SrcA      = 32'h0000_0001;
    bus.SrcB      = 32'h0000_000A;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", bus.ALUResult, 32'h0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    issue(4'b0010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Multi-cycle ALU execution unit that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a registered result. Logical, arithmetic and compare operations complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter, so the unit uses a valid/ready handshake on both sides. The pipeline stalls on `in_ready`/`out_valid`. The unit sits in the execute stage between operand selection and the memory/writeback path.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_WIDTH`, default 5: shift-amount width, equal to log2(`DATA_WIDTH`).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `Operation`  in  4  ALU operation code.
- `SrcA`  in  DATA_WIDTH  operand A.
- `SrcB`  in  DATA_WIDTH  operand B. For shifts, bits [SHAMT_WIDTH-1:0] give the shift amount.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Zero`  out  1  registered flag: `ALUResult` == 0.

## Operation
- Operation decode:
  - 0000 AND
  - 0001 SUB
  - 0010 ADD (also used for LW/SW/AUIPC)
  - 0011 OR
  - 0100 XOR
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 EQ (branch): result = {0…, SrcA==SrcB}
  - 1001 SLT (signed)
  - 1010 SLTU (unsigned)
  - 1011–1111: result 0
- Add/sub wrap modulo 2^DATA_WIDTH. No overflow flag.
- SLT/SLTU result is zero-extended 0 or 1.
- Shifts use only SrcB[SHAMT_WIDTH-1:0]; upper bits are ignored.
  - SRA fills with the captured SrcA MSB.
  - SLL/SRL fill with 0.
- Request handshake: a request is accepted on the rising edge where `in_valid` && `in_ready`. Operands and Operation are captured at that edge; inputs are don't-care afterwards.
- State machine:
  - IDLE: `in_ready`=1.
    - Accept of a non-shift op, or a shift with shamt=0: compute, load the result, go to DONE.
    - Accept of a shift with shamt>0: load the working register with SrcA and the counter with shamt, go to SHIFT.
  - SHIFT: `in_ready`=0. Each cycle, shift the working register by 1 and decrement the counter. When the counter reaches 1, that shift completes; load the result and go to DONE.
  - DONE: `out_valid`=1, `in_ready`=0. `ALUResult` and `Zero` are held stable. On `out_ready`=1, return to IDLE.
- `Zero` is updated in the same cycle as `ALUResult`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE
  - `out_valid`=0, `in_ready`=1
  - `ALUResult`=0, `Zero`=0
  - shift counter = 0
- Latency, counted from the accept edge:
  - Non-shift ops and shamt=0: `out_valid` rises after 1 edge.
  - Shift with shamt=k (k>0): `out_valid` rises after k+1 edges.
- Result is held for any number of cycles while `out_ready`=0.
- Output handshake completes on the edge with `out_valid`&&`out_ready`. `in_ready` returns high in the following cycle; no request is accepted in DONE.
- Maximum throughput: one operation per 2 cycles.
- `in_valid` while `in_ready`=0 is ignored. The request is not queued; the upstream stage holds it.
- Reset asserted mid-SHIFT or in DONE aborts the operation and discards the result. After reset deasserts, the first request is accepted normally.
- Shift amount 31 on 32-bit data: 32 cycles from accept to `out_valid`.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001, `out_ready`=1: `out_valid` 1 cycle after accept, `ALUResult`=0, `Zero`=1. `in_ready` is high on the next cycle.
- SUB 5−7 → 0xFFFFFFFE. SLT(0xFFFFFFFE, 1) → 1. SLTU(0xFFFFFFFE, 1) → 0. EQ(0x1234, 0x1234) → 1 with `Zero`=0.
- SRA 0x80000000 by SrcB=0x00000024 (shamt 4): `out_valid` exactly 5 edges after accept, result 0xF8000000. `in_ready`=0 throughout.
- SLL 0x1 by 0 → 0x1 in 1 cycle. SRL 0x80000000 by 31 → 0x1 after 32 edges.
- Back-pressure: XOR 0xF0F0 ^ 0x0FF0 → 0xFF00 with `out_ready`=0 for 4 cycles. Result stays stable and `in_valid` pulses during this time are ignored. `out_ready`=1 completes; the next request is accepted the cycle after.
- Assert `reset` during the third cycle of a shamt-10 SLL: `out_valid`=0, `ALUResult`=0, `in_ready`=1 immediately. After release, ADD 2+3 → 5 in 1 cycle.
